// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D-cache main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_I_BURST = 2'd1,
    ARB_D_BURST = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  localparam int unsigned BYTES_PER_WORD = 32'd4;

endpackage

// File: rtl/mem_arbiter_burst_counter.sv
// Beat counter for one burst: synchronous clear, count enable, last-beat flag.
module burst_counter #(
  parameter int unsigned BLOCK_WORDS = 32'd4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clr_i,
  input  logic                           en_i,
  output logic [$clog2(BLOCK_WORDS)-1:0] cnt_o,
  output logic                           last_o
);

  localparam int unsigned CW = $clog2(BLOCK_WORDS);

  logic [CW-1:0] cnt_r;
  logic          last_s;

  assign last_s = (cnt_r == CW'(BLOCK_WORDS - 32'd1));

  // Beat count; the last beat wraps explicitly so the count never leaves the block.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_r <= '0;
    end else if (en_i && last_s) begin
      cnt_r <= '0;
    end else if (en_i) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt_o  = cnt_r;
  assign last_o = last_s;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the main-memory port between I-cache and D-cache block bursts.
// Build option ARB_ROUND_ROBIN_EN: alternate tie winners; otherwise D-cache wins ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32'd32,
  parameter int unsigned DATA_WIDTH  = 32'd32,
  parameter int unsigned BLOCK_WORDS = 32'd4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           i_req_i,
  input  logic [ADDR_WIDTH-1:0]          i_addr_i,
  output logic                           i_gnt_o,
  output logic                           i_rvalid_o,
  output logic                           i_done_o,
  input  logic                           d_req_i,
  input  logic                           d_we_i,
  input  logic [ADDR_WIDTH-1:0]          d_addr_i,
  input  logic [DATA_WIDTH-1:0]          d_wdata_i,
  output logic                           d_gnt_o,
  output logic                           d_rvalid_o,
  output logic                           d_done_o,
  output logic                           d_beat_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] beat_idx_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  output logic [DATA_WIDTH-1:0]          mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
  input  logic                           mem_ready_i
);

  localparam int unsigned CW = $clog2(BLOCK_WORDS);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BLOCK_WORDS * BYTES_PER_WORD - 32'd1);

  arb_state_e            state_r;
  logic [ADDR_WIDTH-1:0] base_r;
  logic                  we_r;
  owner_e                pick_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic                  in_i_s;
  logic                  in_d_s;
  logic                  beat_s;
  logic                  last_s;
  logic [CW-1:0]         cnt_s;

  assign in_i_s = (state_r == ARB_I_BURST);
  assign in_d_s = (state_r == ARB_D_BURST);
  assign beat_s = (in_i_s || in_d_s) && mem_ready_i;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_win_r;

  // Remember who won the most recent grant so the next tie goes the other way.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_win_r <= OWNER_I;
    end else if ((state_r == ARB_IDLE) && (i_req_i || d_req_i)) begin
      last_win_r <= pick_s;
    end else begin
      last_win_r <= last_win_r;
    end
  end

  // Tie-break: D wins unless it also won last time.
  always_comb begin
    if (d_req_i && (!i_req_i || (last_win_r == OWNER_I))) begin
      pick_s = OWNER_D;
    end else begin
      pick_s = OWNER_I;
    end
  end
`else
  // Fixed priority: any D request beats the I-cache.
  always_comb begin
    if (d_req_i) begin
      pick_s = OWNER_D;
    end else begin
      pick_s = OWNER_I;
    end
  end
`endif

  assign sel_addr_s = (pick_s == OWNER_D) ? d_addr_i : i_addr_i;

  // Burst sequencer: grant in idle, return to idle after the last accepted beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ARB_IDLE;
      base_r  <= '0;
      we_r    <= 1'b0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (i_req_i || d_req_i) begin
            state_r <= (pick_s == OWNER_D) ? ARB_D_BURST : ARB_I_BURST;
            base_r  <= sel_addr_s & ~OFF_MASK;
            we_r    <= (pick_s == OWNER_D) && d_we_i;
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_I_BURST, ARB_D_BURST: begin
          if (beat_s && last_s) begin
            state_r <= ARB_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  burst_counter #(
    .BLOCK_WORDS(BLOCK_WORDS)
  ) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state_r == ARB_IDLE),
    .en_i  (beat_s),
    .cnt_o (cnt_s),
    .last_o(last_s)
  );

  assign i_gnt_o     = in_i_s;
  assign d_gnt_o     = in_d_s;
  assign mem_req_o   = in_i_s || in_d_s;
  assign mem_we_o    = in_d_s && we_r;
  assign mem_addr_o  = (in_i_s || in_d_s) ?
                       (base_r + ADDR_WIDTH'(cnt_s) * ADDR_WIDTH'(BYTES_PER_WORD)) : '0;
  assign mem_wdata_o = in_d_s ? d_wdata_i : '0;
  assign beat_idx_o  = cnt_s;
  assign rdata_o     = beat_s ? mem_rdata_i : '0;
  assign i_rvalid_o  = in_i_s && mem_ready_i;
  assign i_done_o    = in_i_s && mem_ready_i && last_s;
  assign d_beat_o    = in_d_s && mem_ready_i;
  assign d_rvalid_o  = in_d_s && mem_ready_i && !we_r;
  assign d_done_o    = in_d_s && mem_ready_i && last_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed and random bursts.
module tb_mem_arbiter;

  localparam int BW = 4;
  localparam int CW = 2;

  logic        clk_i = 1'b0;
  logic        rst_i, i_req_i, d_req_i, d_we_i, mem_ready_i;
  logic [31:0] i_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
  logic        i_gnt_o, i_rvalid_o, i_done_o, d_gnt_o, d_rvalid_o, d_done_o, d_beat_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic [CW-1:0] beat_idx_o;

  always #5 clk_i = ~clk_i;

  mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_done_o(i_done_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_done_o(d_done_o), .d_beat_o(d_beat_o),
    .rdata_o(rdata_o), .beat_idx_o(beat_idx_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Transaction-level model: is a burst open, who owns it, where, and how many beats are done.
  bit          m_busy, m_own_d, m_we, m_last_d;
  logic [31:0] m_base;
  int          m_beats;

  int  i_left, d_left;
  bit  auto_wdata, rand_ready, prev_gnt;
  logic [31:0] addr_q[$];
  logic [31:0] wdata_q[$];
  int  idx_q[$];
  int  gnt_q[$];
  int  n_beats, n_irv, n_drv, n_dbeat, n_we, n_done, done_beat, done_cyc, tcyc;

  task automatic expect_eq(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [106:0] act_vec();
    return {i_gnt_o, i_rvalid_o, i_done_o, d_gnt_o, d_rvalid_o, d_done_o, d_beat_o,
            mem_req_o, mem_we_o, beat_idx_o, mem_addr_o, mem_wdata_o, rdata_o};
  endfunction

  task automatic model_compare();
    logic ig, dg, rdy, lst;
    logic [31:0] e_addr;
    ig  = m_busy && !m_own_d;
    dg  = m_busy && m_own_d;
    rdy = m_busy && mem_ready_i;
    lst = (m_beats == BW - 1);
    e_addr = m_busy ? (m_base + 32'(4 * m_beats)) : 32'h0;
    expect_eq("cycle_outputs", {21'h0, act_vec()},
              {21'h0, ig, ig & rdy, ig & rdy & lst, dg, dg & rdy & !m_we, dg & rdy & lst,
               dg & rdy, m_busy, dg & m_we, CW'(m_beats), e_addr,
               dg ? d_wdata_i : 32'h0, rdy ? mem_rdata_i : 32'h0});
  endtask

  task automatic model_update();
    if (rst_i) begin
      m_busy = 1'b0; m_beats = 0; m_last_d = 1'b0;
    end else if (!m_busy) begin
      if (i_req_i || d_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
        m_own_d = d_req_i && (!i_req_i || !m_last_d);
`else
        m_own_d = d_req_i;
`endif
        m_base   = (m_own_d ? d_addr_i : i_addr_i) & ~32'hF;
        m_we     = m_own_d && d_we_i;
        m_busy   = 1'b1;
        m_beats  = 0;
        m_last_d = m_own_d;
      end
    end else if (mem_ready_i) begin
      m_beats++;
      if (m_beats == BW) begin
        m_busy = 1'b0; m_beats = 0;
      end
    end
  endtask

  task automatic clear_logs();
    addr_q.delete(); wdata_q.delete(); idx_q.delete(); gnt_q.delete();
    n_beats = 0; n_irv = 0; n_drv = 0; n_dbeat = 0; n_we = 0; n_done = 0;
    done_beat = -1; done_cyc = -1; tcyc = 0;
  endtask

  task automatic cycle();
    @(negedge clk_i);
    mem_rdata_i = $urandom();
    if (rand_ready) mem_ready_i = ($urandom_range(0, 3) != 0);
    d_wdata_i = auto_wdata ? (32'hA0 + 32'(beat_idx_o)) : $urandom();
    #2;
    model_compare();
    if (i_rvalid_o || d_beat_o) begin
      n_beats++;
      addr_q.push_back(mem_addr_o);
      idx_q.push_back(int'(beat_idx_o));
      if (d_beat_o) wdata_q.push_back(mem_wdata_o);
    end
    n_irv += int'(i_rvalid_o);
    n_drv += int'(d_rvalid_o);
    n_dbeat += int'(d_beat_o);
    n_we += int'(mem_we_o && d_beat_o);
    if (i_done_o || d_done_o) begin
      n_done++; done_beat = n_beats; done_cyc = tcyc;
    end
    if ((i_gnt_o || d_gnt_o) && !prev_gnt) gnt_q.push_back(int'(d_gnt_o));
    prev_gnt = i_gnt_o || d_gnt_o;
    // Requesters release after done unless they still have another block to move.
    if (i_done_o) begin
      i_left--;
      if (i_left <= 0) i_req_i = 1'b0;
    end
    if (d_done_o) begin
      d_left--;
      if (d_left <= 0) d_req_i = 1'b0;
    end
    @(posedge clk_i);
    model_update();
    tcyc++;
    #1;
  endtask

  task automatic run_until_idle(input int limit);
    int g = 0;
    while ((i_req_i || d_req_i || m_busy) && g < limit) begin
      cycle();
      g++;
    end
    expect_eq("run_bound", {127'h0, g < limit}, 128'h1);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) cycle();
    rst_i = 1'b0;
  endtask

  bit   pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [3:0] order;

  initial begin
    rst_i = 1'b1; i_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0; mem_ready_i = 1'b0;
    i_addr_i = 32'h0; d_addr_i = 32'h0; d_wdata_i = 32'h0; mem_rdata_i = 32'h0;
    i_left = 0; d_left = 0; auto_wdata = 1'b0; rand_ready = 1'b0; prev_gnt = 1'b0;
    m_busy = 1'b0; m_own_d = 1'b0; m_we = 1'b0; m_last_d = 1'b0; m_base = 32'h0; m_beats = 0;
    clear_logs();

    do_reset();
    expect_eq("reset_outputs", {21'h0, act_vec()}, 128'h0);

    // Single I refill.
    clear_logs();
    mem_ready_i = 1'b1; i_addr_i = 32'h0000_1234; i_req_i = 1'b1; i_left = 1;
    run_until_idle(20);
    expect_eq("i_beats", 128'(addr_q.size()), 128'd4);
    expect_eq("i_addr0", {96'h0, addr_q[0]}, 128'h1230);
    expect_eq("i_addr1", {96'h0, addr_q[1]}, 128'h1234);
    expect_eq("i_addr2", {96'h0, addr_q[2]}, 128'h1238);
    expect_eq("i_addr3", {96'h0, addr_q[3]}, 128'h123C);
    expect_eq("i_rvalid_cnt", 128'(n_irv), 128'd4);
    expect_eq("i_done_beat", 128'(done_beat), 128'd4);

    // D write-back with per-beat data.
    clear_logs();
    auto_wdata = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h2000; d_req_i = 1'b1; d_left = 1;
    run_until_idle(20);
    auto_wdata = 1'b0;
    expect_eq("wb_wdata_n", 128'(wdata_q.size()), 128'd4);
    for (int k = 0; k < 4; k++) expect_eq("wb_wdata", {96'h0, wdata_q[k]}, 128'(32'hA0 + k));
    expect_eq("wb_rvalid", 128'(n_drv), 128'd0);
    expect_eq("wb_beats", 128'(n_dbeat), 128'd4);
    expect_eq("wb_we", 128'(n_we), 128'd4);

    // Simultaneous requests right after reset, two blocks each.
    do_reset();
    clear_logs();
    d_we_i = 1'b0; i_addr_i = 32'h100; d_addr_i = 32'h200;
    i_req_i = 1'b1; d_req_i = 1'b1; i_left = 2; d_left = 2;
    run_until_idle(60);
    expect_eq("tie_grants", 128'(gnt_q.size()), 128'd4);
    order = 4'h0;
    for (int k = 0; k < 4 && k < gnt_q.size(); k++) order[3-k] = gnt_q[k][0];
`ifdef ARB_ROUND_ROBIN_EN
    expect_eq("tie_order", {124'h0, order}, 128'hA);
`else
    expect_eq("tie_order", {124'h0, order}, 128'hC);
`endif

    // Wait states 1,0,0,1,1,0,1.
    clear_logs();
    mem_ready_i = 1'b0; i_addr_i = 32'h3000; i_req_i = 1'b1; i_left = 1;
    cycle();
    for (int k = 0; k < 7; k++) begin
      mem_ready_i = pat[k];
      cycle();
    end
    expect_eq("ws_beats", 128'(n_beats), 128'd4);
    expect_eq("ws_done_cyc", 128'(done_cyc), 128'd7);
    expect_eq("ws_done_n", 128'(n_done), 128'd1);
    expect_eq("ws_addr3", {96'h0, addr_q[3]}, 128'h300C);
    mem_ready_i = 1'b1;
    run_until_idle(10);

    // Address wrap at the top of memory, then a fresh burst from index 0.
    clear_logs();
    d_we_i = 1'b0; d_addr_i = 32'hFFFF_FFF0; d_req_i = 1'b1; d_left = 1;
    run_until_idle(20);
    expect_eq("wrap_addr0", {96'h0, addr_q[0]}, 128'hFFFF_FFF0);
    expect_eq("wrap_addr3", {96'h0, addr_q[3]}, 128'hFFFF_FFFC);
    expect_eq("wrap_idx_idle", {126'h0, beat_idx_o}, 128'h0);
    clear_logs();
    d_addr_i = 32'h40; d_req_i = 1'b1; d_left = 1;
    run_until_idle(20);
    expect_eq("wrap_next_idx0", 128'(idx_q[0]), 128'd0);
    expect_eq("wrap_next_beats", 128'(idx_q.size()), 128'd4);

    // Reset in the middle of an I burst.
    clear_logs();
    i_addr_i = 32'h500; i_req_i = 1'b1; i_left = 1;
    repeat (3) cycle();
    rst_i = 1'b1; i_req_i = 1'b0; i_left = 0;
    cycle();
    rst_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'h600; d_req_i = 1'b1; d_left = 1;
    expect_eq("rst_outputs", {21'h0, act_vec()}, 128'h0);
    expect_eq("rst_no_done", 128'(n_done), 128'd0);
    cycle();
    expect_eq("rst_d_gnt", {127'h0, d_gnt_o}, 128'h1);
    run_until_idle(20);

    // Random traffic with random wait states.
    rand_ready = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!i_req_i && $urandom_range(0, 3) == 0) begin
        i_addr_i = $urandom(); i_left = $urandom_range(1, 2); i_req_i = 1'b1;
      end
      if (!d_req_i && $urandom_range(0, 3) == 0) begin
        d_addr_i = $urandom(); d_we_i = $urandom_range(0, 1); d_left = $urandom_range(1, 2);
        d_req_i = 1'b1;
      end
      cycle();
    end
    i_left = 1; d_left = 1;
    run_until_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
